// File: rtl/coeff_replay_fifo_if.sv
// coeff_replay_fifo_if: bus between the coefficient loader, the replay store and the evaluator
// master: drives wr_en_i, data_i, rd_en_i, redo_i and clear_i; observes the read data and status
// slave : the replay store; drives data_o, rd_valid_o, last_o, start_o, full_o, empty_o and count_o
interface coeff_replay_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
    logic              wr_en_i;
    logic [DATA_W-1:0] data_i;
    logic              rd_en_i;
    logic              redo_i;
    logic              clear_i;
    logic [DATA_W-1:0] data_o;
    logic              rd_valid_o;
    logic              last_o;
    logic              start_o;
    logic              full_o;
    logic              empty_o;
    logic [AW:0]       count_o;
    modport master (
        output wr_en_i, data_i, rd_en_i, redo_i, clear_i,
        input  data_o, rd_valid_o, last_o, start_o, full_o, empty_o, count_o
    );
    modport slave (
        input  wr_en_i, data_i, rd_en_i, redo_i, clear_i,
        output data_o, rd_valid_o, last_o, start_o, full_o, empty_o, count_o
    );
endinterface

// File: rtl/coeff_replay_fifo.sv
// coeff_replay_fifo: coefficient store loaded once and replayed cyclically to the evaluator
// clk_i, rstn_i (async assert, sync release, active-low); bus: coeff_replay_fifo_if.slave
module coeff_replay_fifo #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 16,
    parameter logic [31:0] START_TOKEN = 32'h7F90_0000
) (
    input logic               clk_i,
    input logic               rstn_i,
    coeff_replay_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] TOKEN = DATA_W'(START_TOKEN);
    logic [1:0]        rst_sync;
    logic              rstn;
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_idx;
    logic [AW:0]       count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              is_tok, wr_ok, tok_ok, rd_ok, rd_last;
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rstn = rst_sync[1];
    assign bus.count_o = count;
    assign bus.full_o  = count == (AW+1)'(DEPTH);
    assign bus.empty_o = count == '0;
    // redo rewinds before the read so a same-cycle read returns entry 0
    always_comb begin
        is_tok  = bus.data_i == TOKEN;
        wr_ok   = bus.wr_en_i && !is_tok && !bus.full_o && !bus.clear_i;
        tok_ok  = bus.wr_en_i && is_tok && !bus.clear_i && !bus.empty_o;
        rd_ok   = bus.rd_en_i && !bus.empty_o && !bus.clear_i;
        rd_idx  = bus.redo_i ? '0 : rd_ptr;
        rd_last = {1'b0, rd_idx} == count - (AW+1)'(1);
    end
    always_ff @(posedge clk_i)
        if (wr_ok) mem[wr_ptr] <= bus.data_i;
    always_ff @(posedge clk_i or negedge rstn)
        if (!rstn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.data_o     <= '0;
            bus.rd_valid_o <= 1'b0;
            bus.last_o     <= 1'b0;
            bus.start_o    <= 1'b0;
        end else begin
            bus.start_o    <= tok_ok;
            bus.rd_valid_o <= rd_ok;
            bus.last_o     <= rd_ok && rd_last;
            if (rd_ok) bus.data_o <= mem[rd_idx];
            if (bus.clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                if (rd_ok) rd_ptr <= rd_last ? '0 : rd_idx + 1'b1;
                else if (bus.redo_i) rd_ptr <= '0;
            end
        end
endmodule

// File: tb/tb_coeff_replay_fifo.sv
// tb_coeff_replay_fifo: randomized and directed checks of coeff_replay_fifo against a queue model
module tb_coeff_replay_fifo;
    localparam int DEPTH = 16;
    localparam logic [31:0] TOKEN = 32'h7F90_0000;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] mq[$];
    int mrp = 0;
    logic [31:0] e_data = '0;
    bit e_valid = 0, e_last = 0, e_start = 0;
    coeff_replay_fifo_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();
    coeff_replay_fifo #(.DATA_W(32), .DEPTH(DEPTH), .START_TOKEN(TOKEN)) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    task automatic model_reset();
        mq.delete();
        mrp = 0;
        e_data = '0;
        e_valid = 0;
        e_last = 0;
        e_start = 0;
    endtask
    // drive one cycle at the falling edge, predict from pre-edge state, return 1 time unit after the rising edge
    task automatic cyc(bit wr, logic [31:0] d, bit rd, bit rdo, bit clr);
        int idx;
        @(negedge clk);
        bus.wr_en_i = wr;
        bus.data_i  = d;
        bus.rd_en_i = rd;
        bus.redo_i  = rdo;
        bus.clear_i = clr;
        e_start = wr && d == TOKEN && !clr && mq.size() != 0;
        e_valid = rd && mq.size() != 0 && !clr;
        e_last  = 0;
        if (clr) begin
            mq.delete();
            mrp = 0;
        end else begin
            idx = rdo ? 0 : mrp;
            if (e_valid) begin
                e_data = mq[idx];
                e_last = idx == mq.size() - 1;
                mrp = (idx + 1) % mq.size();
            end else if (rdo) mrp = 0;
            if (wr && d != TOKEN && mq.size() < DEPTH) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.wr_en_i = 0; bus.data_i = '0; bus.rd_en_i = 0; bus.redo_i = 0; bus.clear_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) cyc(0, '0, 0, 0, 0);
    endtask
    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        return (w == TOKEN) ? 32'h1 : w;
    endfunction
    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.data_o); end
        n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.rd_valid_o); end
        n_cmp++; if (bus.last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", bus.last_o); end
        n_cmp++; if (bus.start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", bus.start_o); end
        n_cmp++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full_o); end
        n_cmp++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty_o); end
        n_cmp++; if (bus.count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    endtask
    task automatic test_empty();
        cyc(0, '0, 1, 0, 0);
        n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL empty_valid got %b want 0", bus.rd_valid_o); end
        n_cmp++; if (bus.data_o !== 32'h0) begin n_fail++; $display("FAIL empty_data got %h want 0", bus.data_o); end
        cyc(1, TOKEN, 0, 0, 0);
        n_cmp++; if (bus.start_o !== 1'b0) begin n_fail++; $display("FAIL empty_token_start got %b want 0", bus.start_o); end
        n_cmp++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL empty_token_empty got %b want 1", bus.empty_o); end
    endtask
    task automatic test_load_replay();
        logic [31:0] w [3];
        w[0] = 32'h3F80_0000; w[1] = 32'h4000_0000; w[2] = 32'h4040_0000;
        for (int i = 0; i < 3; i++) cyc(1, w[i], 0, 0, 0);
        cyc(1, TOKEN, 0, 0, 0);
        n_cmp++; if (bus.start_o !== 1'b1) begin n_fail++; $display("FAIL load_start got %b want 1", bus.start_o); end
        n_cmp++; if (bus.count_o !== 5'd3) begin n_fail++; $display("FAIL load_count got %0d want 3", bus.count_o); end
        cyc(0, '0, 0, 0, 0);
        n_cmp++; if (bus.start_o !== 1'b0) begin n_fail++; $display("FAIL load_start_width got %b want 0", bus.start_o); end
        for (int i = 0; i < 6; i++) begin
            cyc(0, '0, 1, 0, 0);
            n_cmp++; if (bus.data_o !== w[i%3]) begin n_fail++; $display("FAIL replay_data[%0d] got %h want %h", i, bus.data_o, w[i%3]); end
            n_cmp++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL replay_valid[%0d] got %b want 1", i, bus.rd_valid_o); end
            n_cmp++; if (bus.last_o !== (i % 3 == 2)) begin n_fail++; $display("FAIL replay_last[%0d] got %b want %b", i, bus.last_o, i % 3 == 2); end
        end
    endtask
    task automatic test_overflow();
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'(i), 0, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        n_cmp++; if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", bus.full_o); end
        n_cmp++; if (bus.count_o !== 5'(DEPTH)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", bus.count_o, DEPTH); end
        cyc(1, TOKEN, 0, 0, 0);
        n_cmp++; if (bus.start_o !== 1'b1) begin n_fail++; $display("FAIL ovf_token_start got %b want 1", bus.start_o); end
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(0, '0, 1, 0, 0);
            n_cmp++; if (bus.data_o !== 32'(i % DEPTH)) begin n_fail++; $display("FAIL ovf_replay[%0d] got %h want %h", i, bus.data_o, 32'(i % DEPTH)); end
            n_cmp++; if (bus.last_o !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL ovf_last[%0d] got %b want %b", i, bus.last_o, i == DEPTH - 1); end
        end
    endtask
    task automatic test_redo();
        logic [31:0] w [4];
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            w[i] = rnd_word();
            cyc(1, w[i], 0, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, '0, 1, 0, 0);
            n_cmp++; if (bus.data_o !== w[i]) begin n_fail++; $display("FAIL redo_pre[%0d] got %h want %h", i, bus.data_o, w[i]); end
        end
        cyc(0, '0, 1, 1, 0);
        n_cmp++; if (bus.data_o !== w[0]) begin n_fail++; $display("FAIL redo_first got %h want %h", bus.data_o, w[0]); end
        cyc(0, '0, 1, 0, 0);
        n_cmp++; if (bus.data_o !== w[1]) begin n_fail++; $display("FAIL redo_second got %h want %h", bus.data_o, w[1]); end
    endtask
    task automatic test_clear();
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, rnd_word(), 0, 0, 0);
        cyc(1, rnd_word(), 1, 0, 1);
        n_cmp++; if (bus.count_o !== 5'd0) begin n_fail++; $display("FAIL clear_count got %0d want 0", bus.count_o); end
        n_cmp++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL clear_empty got %b want 1", bus.empty_o); end
        n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %b want 0", bus.rd_valid_o); end
        cyc(1, 32'h1234_5678, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        n_cmp++; if (bus.data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL clear_reload got %h want 12345678", bus.data_o); end
        n_cmp++; if (bus.last_o !== 1'b1) begin n_fail++; $display("FAIL clear_reload_last got %b want 1", bus.last_o); end
    endtask
    task automatic test_random();
        bit wr, rd, rdo, clr;
        logic [31:0] d;
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            wr  = $urandom_range(0, 1) == 1;
            d   = ($urandom_range(0, 7) == 0) ? TOKEN : rnd_word();
            rd  = $urandom_range(0, 1) == 1;
            rdo = $urandom_range(0, 9) == 0;
            clr = $urandom_range(0, 39) == 0;
            cyc(wr, d, rd, rdo, clr);
            n_cmp++; if (bus.data_o !== e_data) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, bus.data_o, e_data); end
            n_cmp++; if (bus.rd_valid_o !== e_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.rd_valid_o, e_valid); end
            n_cmp++; if (bus.last_o !== e_last) begin n_fail++; $display("FAIL rnd_last[%0d] got %b want %b", i, bus.last_o, e_last); end
            n_cmp++; if (bus.start_o !== e_start) begin n_fail++; $display("FAIL rnd_start[%0d] got %b want %b", i, bus.start_o, e_start); end
            n_cmp++; if (bus.count_o !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, bus.count_o, mq.size()); end
            n_cmp++; if (bus.full_o !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full[%0d] got %b", i, bus.full_o); end
            n_cmp++; if (bus.empty_o !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d] got %b", i, bus.empty_o); end
        end
    endtask
    task automatic test_async_reset();
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, rnd_word(), 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);
        n_cmp++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got %b want 1", bus.rd_valid_o); end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", bus.rd_valid_o); end
        n_cmp++; if (bus.data_o !== 32'h0) begin n_fail++; $display("FAIL areset_data got %h want 0", bus.data_o); end
        n_cmp++; if (bus.count_o !== 5'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", bus.count_o); end
        n_cmp++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL areset_empty got %b want 1", bus.empty_o); end
        n_cmp++; if (bus.last_o !== 1'b0) begin n_fail++; $display("FAIL areset_last got %b want 0", bus.last_o); end
        do_reset();
        cyc(0, '0, 1, 0, 0);
        n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_after_valid got %b want 0", bus.rd_valid_o); end
    endtask
    initial begin
        bus.wr_en_i = 0; bus.data_i = '0; bus.rd_en_i = 0; bus.redo_i = 0; bus.clear_i = 0;
        test_reset();
        test_empty();
        test_load_replay();
        test_overflow();
        test_redo();
        test_clear();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
